// File: rtl/tx_serial_7o1.sv
// tx_serial_7o1: 7O1 UART transmitter, one start bit, 7 data bits LSB first, odd parity, one stop bit
module tx_serial_7o1 #(
  parameter int M = 434,
  parameter int N = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [6:0] dados_ascii,
  output logic       saida_serial,
  output logic       pronto,
  output logic       em_transmissao,
  output logic [3:0] db_estado
);
  typedef enum logic [3:0] {
    OCIOSO     = 4'b0000,
    PREPARACAO = 4'b0001,
    TRANSMISSAO = 4'b0101,
    FINAL_TX   = 4'b1111
  } state_t;
  state_t state_q, state_d;
  logic [9:0] sr_q, sr_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic bit_end;
  assign bit_end = cnt_q == N'(M - 1);
  // state and datapath registers; reset returns the line to idle immediately
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= OCIOSO;
      sr_q    <= '1;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end
  // next state, frame shifting and outputs decoded from registered state only
  always_comb begin
    state_d        = state_q;
    sr_d           = sr_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    saida_serial   = 1'b1;
    pronto         = 1'b0;
    em_transmissao = 1'b0;
    db_estado      = state_q;
    case (state_q)
      OCIOSO: begin
        state_d = partida ? PREPARACAO : OCIOSO;
        sr_d    = partida ? {1'b1, ~^dados_ascii, dados_ascii, 1'b0} : sr_q;
      end
      PREPARACAO: begin
        em_transmissao = 1'b1;
        cnt_d          = '0;
        idx_d          = '0;
        state_d        = TRANSMISSAO;
      end
      TRANSMISSAO: begin
        em_transmissao = 1'b1;
        saida_serial   = sr_q[0];
        cnt_d          = bit_end ? '0 : cnt_q + N'(1);
        sr_d           = bit_end ? {1'b1, sr_q[9:1]} : sr_q;
        idx_d          = !bit_end ? idx_q : (idx_q == 4'd9) ? 4'd0 : idx_q + 4'd1;
        state_d        = (bit_end && idx_q == 4'd9) ? FINAL_TX : TRANSMISSAO;
      end
      FINAL_TX: begin
        pronto  = 1'b1;
        state_d = OCIOSO;
      end
      default: begin
        db_estado = 4'b1110;
        state_d   = OCIOSO;
      end
    endcase
  end
endmodule
